// File: rtl/spi_cmd_arbiter_pkg.sv
// Shared constants and types for the SPI command sequencer and its target:
// command codes, request op encoding, sequencer state encoding.
package spi_cmd_pkg;

  localparam logic [7:0] CMD_READ   = 8'h03;
  localparam logic [7:0] CMD_WRITE  = 8'h02;
  localparam logic [7:0] CMD_STREAM = 8'h80;
  // Fill byte between transactions; deliberately distinct from every command code
  localparam logic [7:0] IDLE_BYTE  = 8'h00;

  // Address bit 4 selects the result register instead of the 16-byte memory
  localparam int RES_ADDR_BIT = 4;

  typedef enum logic [1:0] {
    OP_READ   = 2'd0,
    OP_WRITE  = 2'd1,
    OP_STREAM = 2'd2,
    OP_RSVD   = 2'd3
  } op_t;

  typedef enum logic [2:0] {
    ST_RESYNC,
    ST_IDLE,
    ST_CMD,
    ST_ADDR,
    ST_DATA,
    ST_RDWAIT
  } state_t;

  // The reserved op behaves exactly like a stream
  function automatic logic is_stream(input op_t op);
    return (op == OP_STREAM) || (op == OP_RSVD);
  endfunction

  function automatic logic [7:0] cmd_code(input op_t op);
    logic [7:0] code;
    case (op)
      OP_READ:  code = CMD_READ;
      OP_WRITE: code = CMD_WRITE;
      default:  code = CMD_STREAM;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/spi_cmd_arbiter_if.sv
// Request/response bundle between the two requesters and the SPI command
// sequencer. Requesters drive the request side, the sequencer answers.
interface spi_cmd_arbiter_if;

  logic [1:0]      req_valid;
  logic [1:0]      req_ready;
  logic [1:0][1:0] req_op;
  logic [1:0][4:0] req_addr;
  logic [1:0][7:0] req_data;

  logic            rsp_valid;
  logic            rsp_id;
  logic [7:0]      rsp_data;

  modport master (
    output req_valid, req_op, req_addr, req_data,
    input  req_ready, rsp_valid, rsp_id, rsp_data
  );

  modport slave (
    input  req_valid, req_op, req_addr, req_data,
    output req_ready, rsp_valid, rsp_id, rsp_data
  );

endinterface

// File: rtl/spi_rr_arb2.sv
// Two-way round-robin grant. When both requesters are valid, the one that
// was not served last wins; after reset requester 0 is preferred.
module spi_rr_arb2 (
  input  logic       sclk,
  input  logic       rst,
  input  logic [1:0] req_valid,
  input  logic       enable,
  output logic [1:0] grant
);

  // Requester that wins the next tie
  logic prio_q;

  // Combinational grant, only while the sequencer can accept a request
  always_comb begin
    grant = 2'b00;
    if (enable) begin
      case (req_valid)
        2'b01:   grant = 2'b01;
        2'b10:   grant = 2'b10;
        2'b11:   grant = prio_q ? 2'b10 : 2'b01;
        default: grant = 2'b00;
      endcase
    end
  end

  // A grant is always a handshake, so the loser of this round gets the next tie
  always_ff @(posedge sclk or posedge rst) begin
    if (rst) begin
      prio_q <= 1'b0;
    end else if (|grant) begin
      prio_q <= ~grant[1];
    end
  end

endmodule

// File: rtl/spi_cmd_arbiter.sv
// Sequencer that owns the SPI target command port: arbitrates two requesters,
// expands each accepted op into its CMD/ADDR/DATA byte sequence and returns
// read data one cycle after the read-wait cycle.
module spi_cmd_arbiter
  import spi_cmd_pkg::*;
(
  input  logic                 sclk,
  input  logic                 rst,
  spi_cmd_arbiter_if.slave     bus,
  output logic                 spi_rst_n,
  output logic                 spi_cs,
  output logic [7:0]           spi_mosi,
  input  logic [7:0]           spi_miso
);

  state_t     state_q, state_d;
  op_t        op_q;
  logic [4:0] addr_q;
  logic [7:0] data_q;
  logic       id_q;

  logic [1:0] grant;
  logic       handshake;
  logic       sel_id;
  op_t        sel_op;

  logic [7:0] mosi_d;
  logic       cs_d;
  logic       rst_n_d;
  logic       rsp_valid_d;
  logic       capture;

  spi_rr_arb2 u_arb (
    .sclk      (sclk),
    .rst       (rst),
    .req_valid (bus.req_valid),
    .enable    (state_q == ST_IDLE),
    .grant     (grant)
  );

  assign bus.req_ready = grant;
  assign handshake     = |grant;
  assign sel_id        = grant[1];
  assign sel_op        = op_t'(bus.req_op[sel_id]);

  // Next state plus the byte/strobe values that will be on the wires next cycle
  always_comb begin
    state_d     = state_q;
    mosi_d      = IDLE_BYTE;
    cs_d        = 1'b0;
    rst_n_d     = 1'b1;
    rsp_valid_d = 1'b0;
    capture     = 1'b0;
    case (state_q)
      ST_RESYNC: state_d = ST_IDLE;
      ST_IDLE: begin
        if (handshake) begin
          state_d = ST_CMD;
          mosi_d  = cmd_code(sel_op);
          cs_d    = 1'b1;
        end
      end
      ST_CMD: begin
        cs_d = 1'b1;
        if (is_stream(op_q)) begin
          state_d = ST_DATA;
          mosi_d  = data_q;
        end else begin
          state_d = ST_ADDR;
          mosi_d  = {3'b000, addr_q};
        end
      end
      ST_ADDR: begin
        if (op_q == OP_WRITE) begin
          state_d = ST_DATA;
          mosi_d  = data_q;
          cs_d    = 1'b1;
        end else begin
          state_d = ST_RDWAIT;
        end
      end
      ST_DATA: state_d = ST_IDLE;
      ST_RDWAIT: begin
        state_d     = ST_IDLE;
        rsp_valid_d = 1'b1;
        capture     = 1'b1;
      end
      default: begin
        state_d = ST_RESYNC;
        rst_n_d = 1'b0;
      end
    endcase
  end

  // State and registered target-side outputs; reset holds the target in reset
  always_ff @(posedge sclk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_RESYNC;
      spi_rst_n <= 1'b0;
      spi_cs    <= 1'b0;
      spi_mosi  <= IDLE_BYTE;
    end else begin
      state_q   <= state_d;
      spi_rst_n <= rst_n_d;
      spi_cs    <= cs_d;
      spi_mosi  <= mosi_d;
    end
  end

  // Snapshot of the granted request; later changes on the inputs are ignored
  always_ff @(posedge sclk or posedge rst) begin
    if (rst) begin
      op_q   <= OP_READ;
      addr_q <= 5'd0;
      data_q <= 8'h00;
      id_q   <= 1'b0;
    end else if (handshake) begin
      op_q   <= sel_op;
      addr_q <= bus.req_addr[sel_id];
      data_q <= bus.req_data[sel_id];
      id_q   <= sel_id;
    end
  end

  // Read response: miso captured at the end of the wait cycle, pulsed next cycle
  always_ff @(posedge sclk or posedge rst) begin
    if (rst) begin
      bus.rsp_valid <= 1'b0;
      bus.rsp_id    <= 1'b0;
      bus.rsp_data  <= 8'h00;
    end else begin
      bus.rsp_valid <= rsp_valid_d;
      if (capture) begin
        bus.rsp_id   <= id_q;
        bus.rsp_data <= spi_miso;
      end
    end
  end

endmodule

// File: tb/tb_spi_cmd_arbiter.sv
// Directed bench for spi_cmd_arbiter with a behavioural pattern-match target.
module tb_spi_cmd_arbiter;
  import spi_cmd_pkg::*;

  logic       sclk = 1'b0;
  logic       rst  = 1'b1;
  logic       spi_rst_n;
  logic       spi_cs;
  logic [7:0] spi_mosi;
  logic [7:0] spi_miso;

  int compared   = 0;
  int mismatched = 0;

  bit         grant_q[$];
  logic [8:0] rsp_q[$];

  spi_cmd_arbiter_if bus();

  spi_cmd_arbiter dut (
    .sclk      (sclk),
    .rst       (rst),
    .bus       (bus.slave),
    .spi_rst_n (spi_rst_n),
    .spi_cs    (spi_cs),
    .spi_mosi  (spi_mosi),
    .spi_miso  (spi_miso)
  );

  always #5 sclk = ~sclk;

  // Target: entries 0..7 are characters, 8..15 their don't-care masks;
  // a streamed character sets result bit i (sticky) when entry i matches.
  logic [7:0] tmem [16] = '{default: 8'h00};
  logic [7:0] tres   = 8'h00;
  logic [7:0] tcmd   = 8'h00;
  logic [4:0] taddr  = 5'd0;
  logic [7:0] miso_r = 8'h00;
  int         tphase = 0;

  assign spi_miso = miso_r;

  always @(posedge sclk) begin
    if (!spi_rst_n || !spi_cs) begin
      tphase <= 0;
    end else begin
      case (tphase)
        0: begin
          tcmd   <= spi_mosi;
          tphase <= 1;
        end
        1: begin
          if (tcmd == CMD_STREAM) begin
            for (int i = 0; i < 8; i++)
              if (((spi_mosi ^ tmem[i]) & ~tmem[i+8]) == 8'h00) tres[i] <= 1'b1;
            tphase <= 0;
          end else begin
            taddr <= spi_mosi[4:0];
            if (tcmd == CMD_READ) begin
              miso_r <= spi_mosi[RES_ADDR_BIT] ? tres : tmem[spi_mosi[3:0]];
              tphase <= 0;
            end else begin
              tphase <= 2;
            end
          end
        end
        default: begin
          if (taddr[RES_ADDR_BIT]) tres <= spi_mosi;
          else tmem[taddr[3:0]] <= spi_mosi;
          tphase <= 0;
        end
      endcase
    end
  end

  // Log handshakes and responses mid-cycle, after the bench has driven inputs
  always @(negedge sclk) begin
    #2;
    if (!rst) begin
      if (|(bus.req_valid & bus.req_ready)) grant_q.push_back(bus.req_ready[1]);
      if (bus.rsp_valid) rsp_q.push_back({bus.rsp_id, bus.rsp_data});
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish by %0t", $time);
    $fatal(1, "[TB] watchdog");
  end

  task automatic do_req(input int id, input logic [1:0] op, input logic [4:0] addr,
                        input logic [7:0] data, input string name);
    bit ok = 1'b0;
    @(negedge sclk);
    bus.req_op[id]    = op;
    bus.req_addr[id]  = addr;
    bus.req_data[id]  = data;
    bus.req_valid[id] = 1'b1;
    for (int n = 0; n < 40 && !ok; n++) begin
      #1;
      if (bus.req_ready[id]) ok = 1'b1;
      else @(negedge sclk);
    end
    compared++;
    if (!ok) begin
      mismatched++;
      $display("[TB] FAIL %s handshake: req_ready=0 after 40 cycles, required 1", name);
      bus.req_valid[id] = 1'b0;
    end else begin
      @(posedge sclk);
      #1;
      bus.req_valid[id] = 1'b0;
    end
  endtask

  task automatic do_read(input int id, input logic [4:0] addr, output logic [7:0] data,
                         output logic rid, output int lat);
    do_req(id, OP_READ, addr, 8'h00, "read");
    lat  = 0;
    data = 8'hxx;
    rid  = 1'bx;
    for (int n = 1; n <= 20 && lat == 0; n++) begin
      @(negedge sclk);
      if (bus.rsp_valid) begin
        lat  = n;
        data = bus.rsp_data;
        rid  = bus.rsp_id;
      end
    end
  endtask

  task automatic check_bytes(input string name, input logic [7:0] b0, input logic [7:0] b1,
                             input logic [7:0] b2, input int count);
    logic [7:0] exp_b [3];
    exp_b[0] = b0;
    exp_b[1] = b1;
    exp_b[2] = b2;
    for (int i = 0; i <= count; i++) begin
      @(negedge sclk);
      compared++;
      if (i < count) begin
        if ({spi_cs, spi_mosi} !== {1'b1, exp_b[i]}) begin
          mismatched++;
          $display("[TB] FAIL %s byte%0d: cs/mosi=%b/%h, required 1/%h", name, i, spi_cs, spi_mosi, exp_b[i]);
        end
      end else if ({spi_cs, spi_mosi} !== {1'b0, IDLE_BYTE}) begin
        mismatched++;
        $display("[TB] FAIL %s idle: cs/mosi=%b/%h, required 0/00", name, spi_cs, spi_mosi);
      end
    end
  endtask

  task automatic check_read(input string name, input logic [7:0] data, input logic rid, input int lat,
                            input logic [7:0] exp_data, input logic exp_id);
    compared++;
    if (lat !== 4 || data !== exp_data || rid !== exp_id) begin
      mismatched++;
      $display("[TB] FAIL %s: lat/data/id=%0d/%h/%b, required 4/%h/%b", name, lat, data, rid, exp_data, exp_id);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.req_valid = 2'b01;
    bus.req_op    = '0;
    bus.req_addr  = '0;
    bus.req_data  = '0;
    bus.req_addr[0] = 5'h01;
    repeat (3) @(negedge sclk);
    compared++;
    if ({spi_rst_n, spi_cs, spi_mosi, bus.req_ready, bus.rsp_valid, bus.rsp_id, bus.rsp_data} !== 22'h0) begin
      mismatched++;
      $display("[TB] FAIL reset_values: rst_n/cs/mosi/ready/rv/rid/rdata=%b/%b/%h/%b/%b/%b/%h, required all 0",
               spi_rst_n, spi_cs, spi_mosi, bus.req_ready, bus.rsp_valid, bus.rsp_id, bus.rsp_data);
    end
    @(posedge sclk);
    #1 rst = 1'b0;
    @(negedge sclk);
    compared++;
    if ({spi_rst_n, spi_mosi, bus.req_ready} !== {1'b0, 8'h00, 2'b00}) begin
      mismatched++;
      $display("[TB] FAIL resync_cycle: rst_n/mosi/ready=%b/%h/%b, required 0/00/00", spi_rst_n, spi_mosi, bus.req_ready);
    end
    @(negedge sclk);
    compared++;
    if ({spi_rst_n, spi_cs, spi_mosi, bus.req_ready} !== {1'b1, 1'b0, 8'h00, 2'b01}) begin
      mismatched++;
      $display("[TB] FAIL first_idle: rst_n/cs/mosi/ready=%b/%b/%h/%b, required 1/0/00/01",
               spi_rst_n, spi_cs, spi_mosi, bus.req_ready);
    end
    @(posedge sclk);
    #1 bus.req_valid = 2'b00;
    repeat (6) @(negedge sclk);
  endtask

  task automatic test_write_read();
    logic [7:0] d;
    logic       rid;
    int         lat;
    do_req(0, OP_WRITE, 5'h03, 8'hA5, "wr03");
    check_bytes("wr03", CMD_WRITE, 8'h03, 8'hA5, 3);
    do_read(0, 5'h03, d, rid, lat);
    check_read("rd03", d, rid, lat, 8'hA5, 1'b0);
  endtask

  task automatic test_data_hold();
    logic [7:0] d;
    logic       rid;
    int         lat;
    do_req(0, OP_WRITE, 5'h06, 8'h77, "wr06");
    bus.req_data[0] = 8'h11;
    bus.req_addr[0] = 5'h07;
    bus.req_op[0]   = OP_READ;
    check_bytes("wr06_hold", CMD_WRITE, 8'h06, 8'h77, 3);
    do_read(0, 5'h06, d, rid, lat);
    check_read("rd06", d, rid, lat, 8'h77, 1'b0);
    do_read(0, 5'h07, d, rid, lat);
    check_read("rd07", d, rid, lat, 8'h00, 1'b0);
  endtask

  task automatic test_round_robin();
    int n = 0;
    rst = 1'b1;
    repeat (2) @(negedge sclk);
    @(posedge sclk);
    #1 rst = 1'b0;
    grant_q.delete();
    rsp_q.delete();
    @(negedge sclk);
    bus.req_op[0]   = OP_READ;
    bus.req_op[1]   = OP_READ;
    bus.req_addr[0] = 5'h03;
    bus.req_addr[1] = 5'h06;
    bus.req_valid   = 2'b11;
    while (grant_q.size() < 4 && n < 100) begin
      @(negedge sclk);
      #3;
      n++;
    end
    @(posedge sclk);
    #1 bus.req_valid = 2'b00;
    repeat (8) @(negedge sclk);
    compared++;
    if (grant_q.size() != 4 || rsp_q.size() != 4) begin
      mismatched++;
      $display("[TB] FAIL rr_counts: grants/rsps=%0d/%0d, required 4/4", grant_q.size(), rsp_q.size());
    end
    for (int i = 0; i < 4 && i < grant_q.size(); i++) begin
      compared++;
      if (grant_q[i] !== i[0]) begin
        mismatched++;
        $display("[TB] FAIL rr_grant%0d: winner=%0d, required %0d", i, grant_q[i], i % 2);
      end
    end
    for (int i = 0; i < 4 && i < rsp_q.size(); i++) begin
      compared++;
      if (rsp_q[i] !== {i[0], (i[0] ? 8'h77 : 8'hA5)}) begin
        mismatched++;
        $display("[TB] FAIL rr_rsp%0d: id/data=%b/%h, required %b/%h", i, rsp_q[i][8], rsp_q[i][7:0],
                 i[0], (i[0] ? 8'h77 : 8'hA5));
      end
    end
  endtask

  task automatic test_pattern();
    logic [7:0] d;
    logic       rid;
    int         lat;
    do_req(1, OP_WRITE, 5'h00, 8'h41, "wr_char");
    do_req(1, OP_WRITE, 5'h08, 8'h01, "wr_mask");
    do_req(1, OP_WRITE, 5'h10, 8'h00, "wr_res");
    do_req(0, OP_STREAM, 5'h1F, 8'h41, "stream41");
    check_bytes("stream41", CMD_STREAM, 8'h41, 8'h00, 2);
    do_read(1, 5'h10, d, rid, lat);
    check_read("res_after_41", d, rid, lat, 8'h01, 1'b1);
    do_req(0, OP_RSVD, 5'h00, 8'h42, "stream42");
    check_bytes("stream42_rsvd", CMD_STREAM, 8'h42, 8'h00, 2);
    do_read(0, 5'h10, d, rid, lat);
    check_read("res_after_42", d, rid, lat, 8'h01, 1'b0);
  endtask

  task automatic test_reset_mid();
    logic [7:0] d;
    logic       rid;
    int         lat;
    do_req(0, OP_WRITE, 5'h02, 8'h5A, "wr02_abort");
    @(negedge sclk);
    @(posedge sclk);
    #1;
    rsp_q.delete();
    rst = 1'b1;
    #1;
    compared++;
    if ({spi_rst_n, spi_cs, spi_mosi} !== {1'b0, 1'b0, IDLE_BYTE}) begin
      mismatched++;
      $display("[TB] FAIL mid_reset_outputs: rst_n/cs/mosi=%b/%b/%h, required 0/0/00", spi_rst_n, spi_cs, spi_mosi);
    end
    @(negedge sclk);
    @(posedge sclk);
    #1 rst = 1'b0;
    @(negedge sclk);
    compared++;
    if (spi_rst_n !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL mid_reset_resync: rst_n=%b, required 0", spi_rst_n);
    end
    repeat (6) @(negedge sclk);
    compared++;
    if (rsp_q.size() != 0) begin
      mismatched++;
      $display("[TB] FAIL mid_reset_no_rsp: responses=%0d, required 0", rsp_q.size());
    end
    do_read(0, 5'h02, d, rid, lat);
    compared++;
    if (lat !== 4 || !(d === 8'h00 || d === 8'h5A)) begin
      mismatched++;
      $display("[TB] FAIL rd02_after_abort: lat/data=%0d/%h, required 4/(00 or 5a)", lat, d);
    end
    do_req(1, OP_WRITE, 5'h04, 8'h3C, "wr04");
    check_bytes("wr04", CMD_WRITE, 8'h04, 8'h3C, 3);
    do_read(1, 5'h04, d, rid, lat);
    check_read("rd04", d, rid, lat, 8'h3C, 1'b1);
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_data_hold();
    test_round_robin();
    test_pattern();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/spi_cmd_arbiter.md
# spi_cmd_arbiter

Sequencer and two-port arbiter that owns the byte-wide command port of the SPI pattern-match register target (16-byte character/mask memory plus result register, byte commands READ 8'h03, WRITE 8'h02, STREAM 8'h80). Two requesters issue single-operation transactions over valid/ready. The block expands each transaction into the 2–3 byte command sequence the target expects, drives idle fill between transactions, and returns read data on a response channel. It sits between the control logic and the target, and is the only driver of the target's mosi and reset.

## Interface
- IDLE_BYTE, 8'h00: byte driven on spi_mosi whenever no transaction is active; must not equal any command code.
- sclk  input  1  clock, shared with the target.
- rst  input  1  asynchronous, active-high reset.
- req_valid  input  2  per-requester request valid (bit i = requester i).
- req_ready  output  2  per-requester accept; handshake when valid&ready on the same edge.
- req_op  input  2x2  per-requester op: 0 = read, 1 = write, 2 = stream, 3 = reserved (treated as stream).
- req_addr  input  2x5  per-requester address; bit4 selects the result register, [3:0] the memory byte; ignored for stream.
- req_data  input  2x8  per-requester write data, or the stream character.
- spi_rst_n  output  1  synchronous active-low reset to the target.
- spi_cs  output  1  high while a transaction's bytes are on spi_mosi.
- spi_mosi  output  8  byte to target, one per sclk.
- spi_miso  input  8  registered read byte from target.
- rsp_valid  output  1  one-cycle pulse carrying read data.
- rsp_id  output  1  requester that issued the read.
- rsp_data  output  8  read data.

## Operation
- States: RESYNC, IDLE, CMD, ADDR, DATA, RDWAIT.
- RESYNC: entered on reset. spi_rst_n = 0, spi_mosi = IDLE_BYTE, req_ready = 0. Lasts exactly one cycle after rst deasserts, then goes to IDLE. This clears a target left mid-command. Target memory is not cleared.
- IDLE: spi_mosi = IDLE_BYTE, spi_cs = 0.
  - req_ready[i] is combinational: 1 only for the requester granted this cycle.
  - Grant is round-robin. If only one requester is valid, it wins. If both are valid, the winner is the one not served last. After reset, requester 0 has priority.
  - On handshake: latch op, addr, data and id; update the last-served pointer; go to CMD.
- CMD: spi_mosi = READ / WRITE / STREAM code, spi_cs = 1.
  - Next state: ADDR for read or write, DATA for stream.
- ADDR: spi_mosi = {3'b000, addr}, spi_cs = 1.
  - Next state: DATA for write, RDWAIT for read.
- DATA: spi_mosi = latched data, spi_cs = 1; next state IDLE.
- RDWAIT: spi_mosi = IDLE_BYTE, spi_cs = 0.
  - Sample spi_miso at the end of this cycle into rsp_data, set rsp_id, pulse rsp_valid in the following cycle.
  - Next state IDLE.
- Requester inputs are sampled only at the handshake. Changes afterwards do not affect the transaction in flight.
- Unused req_valid while busy: req_ready stays 0, no state change.

## Timing
- Reset values: state RESYNC, spi_rst_n 0, spi_cs 0, spi_mosi IDLE_BYTE, req_ready 0, rsp_valid 0, rsp_id 0, rsp_data 8'h00, priority pointer to requester 0.
- All outputs except req_ready are registered.
- Handshake at edge E. The CMD byte is on spi_mosi in cycle E+1.
- Write: bytes in E+1..E+3; next handshake possible at end of E+4.
- Stream: bytes in E+1..E+2; next handshake possible at end of E+3.
- Read: CMD in E+1, ADDR in E+2, target updates miso at the end of E+2, sampled at the end of E+3 (RDWAIT). rsp_valid is high in E+4, coinciding with IDLE. Next handshake possible at end of E+4.
- Throughput: at most one transaction in flight; no response backpressure (rsp consumer must accept every pulse).
- Reset asserted mid-transaction: the in-flight transaction is dropped with no rsp_valid, and RESYNC is re-entered. A partially written byte in the target may or may not land; this is unspecified.

## Structure
- Package spi_cmd_pkg: command codes (READ 8'h03, WRITE 8'h02, STREAM 8'h80), op encoding, state encoding, result-register address bit.
- The target module imports the same command constants.
- One natural sub-module: spi_rr_arb2, the two-way round-robin grant with last-served pointer. The rest is a single FSM.

## Test plan
- Reset release: spi_rst_n low for exactly one cycle after rst falls, spi_mosi = 8'h00 throughout → first req_ready one cycle later.
- Req0 write addr 5'h03 data 8'hA5 → spi_mosi 02,03,A5 on three consecutive cycles with spi_cs = 1. A following read of 5'h03 → rsp_valid with rsp_data A5, rsp_id 0, four cycles after its handshake.
- Both requesters valid continuously with reads → grants alternate 0,1,0,1; each rsp_id matches its issuer.
- Configure character 8'h41 at addr 0 and mask 8'h01 at addr 8, write result (addr 5'h10) = 0, stream 8'h41, read 5'h10 → rsp_data 8'h01. Stream 8'h42 then read 5'h10 → still 8'h01.
- Assert rst during ADDR of a write → no rsp, RESYNC cycle, then a read of that address returns either the old or the new value, and the next transaction completes correctly.
- Req_data changed in the cycle after a write handshake → the target receives the originally latched byte.
